// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: each accepted trigger yields an L-cycle high
// output, with ignore / retrigger / queue-one overlap handling per channel.
module pulse_stretch_mc #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter bit EDGE_DET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_pulse,
    input  logic [CNT_W-1:0]    len,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] clr_ovr,
    output logic [CHANNELS-1:0] out_pulse,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] overrun,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q [CHANNELS];
    state_e             state_d [CHANNELS];
    logic [CNT_W-1:0]   cnt_q   [CHANNELS];
    logic [CNT_W-1:0]   cnt_d   [CHANNELS];
    // Queued length, held as L-1 so GAP can load it straight into cnt.
    logic [CNT_W-1:0]   plen_q  [CHANNELS];
    logic [CNT_W-1:0]   plen_d  [CHANNELS];

    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] in_d_q;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    logic [CHANNELS-1:0] trig;
    logic [CNT_W-1:0]    len_m1;
    logic                m_retrig;
    logic                m_queue;

    // Event detection and shared decode of length / overlap policy.
    always_comb begin
        trig     = EDGE_DET ? (in_pulse & ~in_d_q) : in_pulse;
        len_m1   = (len == '0) ? '0 : (len - ONE);
        m_retrig = (mode == 2'b01);
        m_queue  = (mode == 2'b10);
    end

    // Per-channel next-state: stretch counting, overlap policy, done/overrun.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            plen_d[i]  = plen_q[i];
            pend_d[i]  = pend_q[i];
            out_d[i]   = out_q[i];
            done_d[i]  = 1'b0;
            ovr_d[i]   = ovr_q[i] & ~clr_ovr[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    if (trig[i]) begin
                        state_d[i] = ST_STRETCH;
                        out_d[i]   = 1'b1;
                        cnt_d[i]   = len_m1;
                    end
                end
                ST_STRETCH: begin
                    if (trig[i] && m_retrig) begin
                        cnt_d[i] = len_m1;
                    end else begin
                        if (trig[i]) begin
                            if (m_queue && !pend_q[i]) begin
                                pend_d[i] = 1'b1;
                                plen_d[i] = len_m1;
                            end else begin
                                ovr_d[i] = 1'b1;
                            end
                        end
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end else begin
                            out_d[i]   = 1'b0;
                            done_d[i]  = 1'b1;
                            state_d[i] = pend_d[i] ? ST_GAP : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    // Pending slot is still occupied here, so every policy drops.
                    if (trig[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                    state_d[i] = ST_STRETCH;
                    out_d[i]   = 1'b1;
                    cnt_d[i]   = plen_q[i];
                    pend_d[i]  = 1'b0;
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    out_d[i]   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                plen_q[i]  <= '0;
            end
            pend_q <= '0;
            in_d_q <= '0;
            out_q  <= '0;
            done_q <= '0;
            ovr_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                plen_q[i]  <= plen_d[i];
            end
            pend_q <= pend_d;
            in_d_q <= in_pulse;
            out_q  <= out_d;
            done_q <= done_d;
            ovr_q  <= ovr_d;
        end
    end

    // Any channel not idle keeps busy asserted.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy = busy | (state_q[i] != ST_IDLE);
        end
    end

    assign out_pulse = out_q;
    assign done      = done_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: edge- and level-triggered builds side by side,
// directed scenarios plus randomized traffic against a cycle-count model.
module tb_pulse_stretch_mc;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] in_pulse;
    logic [CH-1:0] clr_ovr;
    logic [W-1:0]  len;
    logic [1:0]    mode;
    logic [CH-1:0] out_e, done_e, ovr_e;
    logic [CH-1:0] out_l, done_l, ovr_l;
    logic          busy_e, busy_l;

    int checks   = 0;
    int failures = 0;
    int hcnt     = 0;
    int dcnt     = 0;

    // Model: k=0 edge build, k=1 level build.
    int rem  [2][CH];
    int qlen [2][CH];
    bit gap  [2][CH];
    bit prv  [2][CH];
    bit mdone[2][CH];
    bit movr [2][CH];

    always #5 clk = ~clk;

    pulse_stretch_mc #(.CHANNELS(CH), .CNT_W(W), .EDGE_DET(1'b1)) dut_e (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .len(len), .mode(mode),
        .clr_ovr(clr_ovr), .out_pulse(out_e), .done(done_e),
        .overrun(ovr_e), .busy(busy_e)
    );

    pulse_stretch_mc #(.CHANNELS(CH), .CNT_W(W), .EDGE_DET(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .len(len), .mode(mode),
        .clr_ovr(clr_ovr), .out_pulse(out_l), .done(done_l),
        .overrun(ovr_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) begin
                rem[k][i] = 0; qlen[k][i] = 0; gap[k][i] = 0;
                prv[k][i] = 0; mdone[k][i] = 0; movr[k][i] = 0;
            end
    endtask

    // rem = high cycles still owed, counting the current one.
    task automatic model_step();
        int l;
        int md;
        bit t;
        bit setv;
        l  = (len == 0) ? 1 : int'(len);
        md = (mode == 2'd3) ? 0 : int'(mode);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) begin
                t = in_pulse[i] && (k == 1 || !prv[k][i]);
                prv[k][i] = in_pulse[i];
                setv = 0;
                mdone[k][i] = 0;
                if (gap[k][i]) begin
                    if (t) setv = 1;
                    gap[k][i]  = 0;
                    rem[k][i]  = qlen[k][i];
                    qlen[k][i] = 0;
                end else if (rem[k][i] == 0) begin
                    if (t) rem[k][i] = l;
                end else if (t && md == 1) begin
                    rem[k][i] = l;
                end else begin
                    if (t) begin
                        if (md == 2 && qlen[k][i] == 0) qlen[k][i] = l;
                        else setv = 1;
                    end
                    rem[k][i] = rem[k][i] - 1;
                    if (rem[k][i] == 0) begin
                        mdone[k][i] = 1;
                        if (qlen[k][i] != 0) gap[k][i] = 1;
                    end
                end
                movr[k][i] = setv | (movr[k][i] & !clr_ovr[i]);
            end
    endtask

    task automatic compare_all();
        logic [CH-1:0] eo, ed, ev;
        logic eb;
        for (int k = 0; k < 2; k++) begin
            eb = 1'b0;
            for (int i = 0; i < CH; i++) begin
                eo[i] = rem[k][i] > 0;
                ed[i] = mdone[k][i];
                ev[i] = movr[k][i];
                eb = eb | (rem[k][i] > 0) | gap[k][i];
            end
            if (k == 0) begin
                chk("out_e", 32'(out_e), 32'(eo));
                chk("done_e", 32'(done_e), 32'(ed));
                chk("ovr_e", 32'(ovr_e), 32'(ev));
                chk("busy_e", 32'(busy_e), 32'(eb));
            end else begin
                chk("out_l", 32'(out_l), 32'(eo));
                chk("done_l", 32'(done_l), 32'(ed));
                chk("ovr_l", 32'(ovr_l), 32'(ev));
                chk("busy_l", 32'(busy_l), 32'(eb));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        hcnt += int'(out_e[0]);
        dcnt += int'(done_e[0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_pulse = '0;
        clr_ovr  = '0;
        while ((busy_e || busy_l) && n < 600) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < 600), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_pulse = '0;
        clr_ovr = '0;
        len = 8'd5;
        mode = 2'd0;
        model_reset();
        #12;
        chk("rst_out", 32'({out_e, out_l}), 32'd0);
        chk("rst_done", 32'({done_e, done_l}), 32'd0);
        chk("rst_ovr", 32'({ovr_e, ovr_l}), 32'd0);
        chk("rst_busy", 32'({busy_e, busy_l}), 32'd0);
        rst = 1'b0;
        tick();

        // T1: IGNORE, L=5, single pulse
        in_pulse[0] = 1'b1;
        tick();
        chk("t1_rise", 32'(out_e[0]), 32'd1);
        in_pulse[0] = 1'b0;
        for (int n = 2; n <= 7; n++) begin
            tick();
            chk("t1_out", 32'(out_e[0]), 32'(n <= 5));
            chk("t1_done", 32'(done_e[0]), 32'(n == 6));
            chk("t1_busy", 32'(busy_e), 32'(n <= 5));
        end
        drain();

        // T2: IGNORE, overlapping pulse dropped, then cleared
        hcnt = 0;
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0; tick();
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        chk("t2_high", 32'(hcnt), 32'd5);
        chk("t2_ovr", 32'(ovr_e[0]), 32'd1);
        clr_ovr[0] = 1'b1; tick();
        clr_ovr[0] = 1'b0;
        chk("t2_clr", 32'(ovr_e[0]), 32'd0);
        drain();

        // T3: RETRIGGER, L=4, pulses three cycles apart
        mode = 2'd1; len = 8'd4;
        hcnt = 0; dcnt = 0;
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0; tick(); tick();
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        chk("t3_high", 32'(hcnt), 32'd7);
        chk("t3_done", 32'(dcnt), 32'd1);
        chk("t3_ovr", 32'(ovr_e[0]), 32'd0);
        drain();

        // T4: QUEUE, L=3 then queued L=6, third pulse lands in GAP
        mode = 2'd2; len = 8'd3;
        hcnt = 0; dcnt = 0;
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0; tick();
        in_pulse[0] = 1'b1; len = 8'd6; tick();
        in_pulse[0] = 1'b0; tick();
        chk("t4_gap", 32'(out_e[0]), 32'd0);
        in_pulse[0] = 1'b1; len = 8'd3; tick();
        in_pulse[0] = 1'b0;
        for (int n = 0; n < 9; n++) tick();
        chk("t4_high", 32'(hcnt), 32'd9);
        chk("t4_done", 32'(dcnt), 32'd2);
        chk("t4_ovr", 32'(ovr_e[0]), 32'd1);
        clr_ovr = '1; tick(); clr_ovr = '0;
        drain();

        // T5: len=0, len=255, level held-high
        mode = 2'd0; len = 8'd0; hcnt = 0;
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        chk("t5_len0", 32'(hcnt), 32'd1);
        drain();
        len = 8'd255; hcnt = 0; dcnt = 0;
        in_pulse[0] = 1'b1; tick();
        in_pulse[0] = 1'b0;
        for (int n = 0; n < 258; n++) tick();
        chk("t5_len255", 32'(hcnt), 32'd255);
        chk("t5_done255", 32'(dcnt), 32'd1);
        drain();
        len = 8'd2;
        in_pulse[1] = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick();
            chk("t5_level", 32'(out_l[1]), 32'((n % 3) != 2));
        end
        drain();

        // T6: reset mid-stretch with a queued stretch, held-high restart
        mode = 2'd2; len = 8'd10;
        in_pulse = '1; tick();
        in_pulse = '0; tick();
        in_pulse = '1; tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_out", 32'({out_e, out_l}), 32'd0);
        chk("t6_busy", 32'({busy_e, busy_l}), 32'd0);
        chk("t6_ovr", 32'({ovr_e, ovr_l}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        hcnt = 0; dcnt = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (n == 0) chk("t6_rise", 32'(out_e), 32'hF);
        end
        chk("t6_high", 32'(hcnt), 32'd10);
        chk("t6_done", 32'(dcnt), 32'd1);
        drain();

        // Randomized bursts, mode changed only while idle
        for (int b = 0; b < 12; b++) begin
            mode = 2'($urandom_range(0, 3));
            for (int n = 0; n < 60; n++) begin
                len = 8'($urandom_range(0, 8));
                in_pulse = CH'($urandom & $urandom);
                clr_ovr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
                tick();
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
